// File: rtl/prep2_pkg.sv
// prep2_pkg: shared definitions for the PREP2 command sequencer.
//   op_e     - command opcodes carried on cmd_op
//   state_e  - sequencer FSM state encoding
//   cmd_t    - one buffered command (opcode + load value), 10 bits
//   hold_cnt_w() - width of the post-load hold-off counter
package prep2_pkg;

  typedef enum logic [1:0] {
    OP_PRE    = 2'b00,
    OP_CMP    = 2'b01,
    OP_BOTH   = 2'b10,
    OP_SETSEL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  typedef struct packed {
    op_e        op;
    logic [7:0] data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  // The counter must be able to hold HOLD_CYCLES-1; a zero hold-off still
  // needs a one-bit register so the declaration stays legal.
  function automatic int hold_cnt_w(input int hold);
    return (hold > 0) ? $clog2(hold + 1) : 1;
  endfunction

endpackage

// File: rtl/prep2_cmd_fifo.sv
// prep2_cmd_fifo: DEPTH x WIDTH synchronous FIFO with show-ahead read data.
//   clk, rst_n        clock, async active-low reset (flushes pointers/count)
//   push, wr_data     write strobe and data; caller never pushes when full
//   pop, rd_data      read strobe and current head; caller never pops when empty
//   full, empty       occupancy flags
module prep2_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  // NOTE: the storage array has no reset; flushing the pointers and count is
  // enough to empty the FIFO, and leaving data unreset keeps it plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers are exactly log2(DEPTH) bits, so increment wraps modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/prep2_loader.sv
// prep2_loader: command sequencer feeding the PREP2 timer/counter.
//   clk, rst_n             clock, async active-low reset
//   cmd_valid/cmd_ready    command handshake; cmd_ready = !full (low in reset)
//   cmd_op, cmd_data       opcode (PRE/CMP/BOTH/SETSEL) and 8-bit value
//   data2                  registered load value, held between loads
//   ldpre, ldcomp          registered single-cycle load strobes
//   sel                    registered counter mux select
//   busy                   FIFO non-empty or FSM not idle
module prep2_loader
  import prep2_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic [7:0] data2,
  output logic       ldpre,
  output logic       ldcomp,
  output logic       sel,
  output logic       busy
);

  localparam int            HCW       = hold_cnt_w(HOLD_CYCLES);
  localparam logic [HCW-1:0] HOLD_INIT = HCW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  state_e           state;
  logic [HCW-1:0]   hold_cnt;
  logic             ready_en;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [CMD_W-1:0] fifo_rd;
  cmd_t             head;

  // Holds cmd_ready low through reset and for the release cycle, so the
  // first acceptance is on the edge after the one that sets this flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  assign cmd_ready = ready_en & ~fifo_full;
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state == ST_IDLE) & ~fifo_empty;
  assign head      = cmd_t'(fifo_rd);
  assign busy      = ~fifo_empty | (state != ST_IDLE);

  prep2_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data ({cmd_op, cmd_data}),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      data2    <= '0;
      ldpre    <= 1'b0;
      ldcomp   <= 1'b0;
      sel      <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle and are overridden only on a
      // load pop; the later non-blocking assignment wins, giving exactly one
      // high cycle without a separate clear path.
      ldpre  <= 1'b0;
      ldcomp <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (pop) begin
            case (head.op)
              OP_PRE: begin
                data2 <= head.data;
                ldpre <= 1'b1;
                state <= ST_LOAD;
              end
              OP_CMP: begin
                data2  <= head.data;
                ldcomp <= 1'b1;
                state  <= ST_LOAD;
              end
              OP_BOTH: begin
                data2  <= head.data;
                ldpre  <= 1'b1;
                ldcomp <= 1'b1;
                state  <= ST_LOAD;
              end
              OP_SETSEL: sel <= head.data[0];
            endcase
          end
        end
        ST_LOAD: begin
          if (HOLD_CYCLES > 0) begin
            hold_cnt <= HOLD_INIT;
            state    <= ST_HOLD;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == '0) state <= ST_IDLE;
          else                hold_cnt <= hold_cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prep2_loader.sv
// tb_prep2_loader: scoreboard bench for prep2_loader (DEPTH=4, HOLD_CYCLES=2).
// Accepted commands are queued in order; a negedge monitor consumes them as
// the DUT shows strobes or SEL changes and compares against the opcode rules.
module tb_prep2_loader;
  import prep2_pkg::*;

  localparam int DEPTH  = 4;
  localparam int HOLD   = 2;
  localparam int PERIOD = 2 + HOLD;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] data2;
  logic       ldpre;
  logic       ldcomp;
  logic       sel;
  logic       busy;

  prep2_loader #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .data2     (data2),
    .ldpre     (ldpre),
    .ldcomp    (ldcomp),
    .sel       (sel),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
  } ent_t;

  ent_t       sb[$];
  int         n_vec = 0;
  int         n_miss = 0;
  int         cyc = 0;
  int         last_strobe_cyc = -1000;
  int         last_gap = 0;
  logic       exp_sel = 1'b0;
  logic [7:0] exp_data2 = 8'h00;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_strobes(input logic [1:0] op);
    case (op)
      OP_PRE:  return 2'b10;
      OP_CMP:  return 2'b01;
      OP_BOTH: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // A SETSEL that rewrites the current level produces nothing visible; such
  // entries are retired whenever a later visible event needs the queue head.
  task automatic skip_silent();
    while (sb.size() > 0 && sb[0].op == OP_SETSEL && sb[0].data[0] == exp_sel)
      void'(sb.pop_front());
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_sel         = 1'b0;
      exp_data2       = 8'h00;
      last_strobe_cyc = -1000;
    end else begin
      if (sel !== exp_sel) begin
        skip_silent();
        if (sb.size() == 0) begin
          check("sel_unexpected", 32'(sel), 32'(exp_sel));
        end else begin
          check("sel_src_op", 32'(sb[0].op), 32'(OP_SETSEL));
          if (sb[0].op == OP_SETSEL) begin
            exp_sel = sel;
            void'(sb.pop_front());
          end
        end
      end
      if (ldpre || ldcomp) begin
        skip_silent();
        if (sb.size() == 0) begin
          check("strobe_unexpected", 32'({ldpre, ldcomp}), 32'd0);
        end else begin
          ent_t e;
          e = sb.pop_front();
          check("strobe_kind", 32'({ldpre, ldcomp}), 32'(exp_strobes(e.op)));
          check("data2_load", 32'(data2), 32'(e.data));
          check("strobe_spacing", 32'((cyc - last_strobe_cyc) >= PERIOD), 32'd1);
          last_gap        = cyc - last_strobe_cyc;
          last_strobe_cyc = cyc;
          exp_data2       = e.data;
        end
      end else begin
        check("data2_hold", 32'(data2), 32'(exp_data2));
      end
    end
  end

  // Driver: presents a command at a negedge and waits (bounded) for cmd_ready.
  task automatic send(input logic [1:0] op, input logic [7:0] d);
    int waited;
    waited = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) check("ready_timeout", 32'(cmd_ready), 32'd1);
    else            sb.push_back('{op, d});
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data2"},  32'(data2),     32'd0);
    check({tag, "_ldpre"},  32'(ldpre),     32'd0);
    check({tag, "_ldcomp"}, 32'(ldcomp),    32'd0);
    check({tag, "_sel"},    32'(sel),       32'd0);
    check({tag, "_busy"},   32'(busy),      32'd0);
    check({tag, "_ready"},  32'(cmd_ready), 32'd0);
  endtask

  initial begin
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 8'h00;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #2;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    check("ready_after_edge", 32'(cmd_ready), 32'd1);

    // 1: latency of a single PRE
    send(OP_PRE, 8'h5A);
    @(negedge clk);
    check("t1_no_strobe_yet", 32'(ldpre), 32'd0);
    @(negedge clk);
    check("t1_ldpre", 32'(ldpre), 32'd1);
    check("t1_ldcomp", 32'(ldcomp), 32'd0);
    check("t1_data2", 32'(data2), 32'h5A);
    @(negedge clk);
    check("t1_ldpre_single", 32'(ldpre), 32'd0);
    check("t1_data2_held", 32'(data2), 32'h5A);
    wait_idle(20);

    // 2: BOTH
    send(OP_BOTH, 8'h33);
    wait_idle(20);
    check("t2_data2", 32'(data2), 32'h33);

    // 3: back-to-back loads are spaced by the hold-off
    send(OP_PRE, 8'h01);
    send(OP_CMP, 8'h02);
    wait_idle(20);
    check("t3_gap", 32'(last_gap), 32'(PERIOD));
    check("t3_busy", 32'(busy), 32'd0);

    // 4: fill while the sequencer is occupied
    send(OP_PRE, 8'h10);
    for (int i = 1; i <= DEPTH; i++) send(OP_PRE, 8'(i));
    check("t4_ready_full", 32'(cmd_ready), 32'd0);
    check("t4_busy_full", 32'(busy), 32'd1);
    send(OP_PRE, 8'h05);
    wait_idle(60);

    // 5: SETSEL 1 then 0 on consecutive pops
    send(OP_SETSEL, 8'h01);
    send(OP_SETSEL, 8'h00);
    @(negedge clk);
    check("t5_sel_hi", 32'(sel), 32'd1);
    @(negedge clk);
    check("t5_sel_lo", 32'(sel), 32'd0);
    wait_idle(20);

    // 6: reset during the LOAD cycle, with a command still queued
    send(OP_PRE, 8'h77);
    send(OP_CMP, 8'h88);
    check("t6_in_load", 32'(ldpre), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6_ready_before_edge", 32'(cmd_ready), 32'd0);
    repeat (8) @(negedge clk);
    check("t6_stays_idle", 32'(busy), 32'd0);

    // Random traffic with irregular gaps
    for (int i = 0; i < 300; i++) begin
      int gap;
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
      repeat (gap) @(negedge clk);
      send(2'($urandom_range(0, 3)), 8'($urandom));
    end
    wait_idle(100);
    skip_silent();
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    check("final_sel", 32'(sel), 32'(exp_sel));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
